seg_pipe_adder: RTL and testbench

- Parametrised, pipelined segmented adder for the approximate-arithmetic library. Next generation of the single-cycle ripple-carry adder: same a+b+cin -> N+1-bit result, but split into SEG-bit segments with one register stage per segment.
- Valid/ready handshake on both sides.
- Per-transaction mode bit selects exact addition or approximate carry-cut addition, where inter-segment carries are forced to 0.
- Sits between operand producers (e.g. DRUM partial-product logic) and downstream accumulators.

---
 rtl/seg_pipe_adder.sv | 133 +++++++++++++
 tb/tb_seg_pipe_adder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder: pipelined segmented adder computing a + b + cin as an
// N+1-bit result. The operands are split into SEG-bit segments and one
// segment is added per pipeline stage. A per-transaction approx bit selects
// carry-cut mode, where the carry between segments is forced to 0.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid, in_ready  input handshake (transfer when both are 1)
//   a, b, cin, approx   operands, carry-in and mode, captured together
//   out_valid, out_ready output handshake (transfer when both are 1)
//   result              {carry out of top segment, N sum bits}
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// pipeline stalls globally when the output holds a result that downstream
// does not take (out_valid && !out_ready). While stalled every register
// holds and in_ready is 0. There is no bubble collapsing.
//
// Pipeline levels 0..STAGES: level 0 captures the transaction, level k+1
// holds the result of stage k. Stage k adds segment k of the operands.
// Operands travel unchanged through the levels, which makes them the skew
// path for the upper segments. The partial sum travels the same way, which
// makes it the deskew path for the lower segments. N must be a multiple of
// SEG.
module seg_pipe_adder #(
  parameter int N   = 16,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         approx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   result
);

  localparam int STAGES = N / SEG;

  // Per-level state: valid, partial sum and raw carry out of the previous stage.
  logic         valid_q  [0:STAGES];
  logic         valid_d  [0:STAGES];
  logic [N-1:0] sum_q    [0:STAGES];
  logic [N-1:0] sum_d    [0:STAGES];
  logic         carry_q  [0:STAGES];
  logic         carry_d  [0:STAGES];
  // Operands and mode are only needed by levels that still feed a stage.
  logic [N-1:0] a_q      [0:STAGES-1];
  logic [N-1:0] a_d      [0:STAGES-1];
  logic [N-1:0] b_q      [0:STAGES-1];
  logic [N-1:0] b_d      [0:STAGES-1];
  logic         approx_q [0:STAGES-1];
  logic         approx_d [0:STAGES-1];

  logic en;

  assign en        = !(valid_q[STAGES] && !out_ready);
  assign in_ready  = en;
  assign out_valid = valid_q[STAGES];
  assign result    = {carry_q[STAGES], sum_q[STAGES]};

  always_comb begin
    logic [SEG:0] seg_sum;
    logic         cin_k;
    seg_sum = '0;
    cin_k   = 1'b0;
    for (int k = 0; k <= STAGES; k++) begin
      valid_d[k] = valid_q[k];
      sum_d[k]   = sum_q[k];
      carry_d[k] = carry_q[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]      = a_q[k];
      b_d[k]      = b_q[k];
      approx_d[k] = approx_q[k];
    end
    if (en) begin
      // Level 0 capture. carry at level 0 is cin, consumed by stage 0.
      valid_d[0]  = in_valid;
      a_d[0]      = a;
      b_d[0]      = b;
      approx_d[0] = approx;
      carry_d[0]  = cin;
      sum_d[0]    = '0;
      for (int k = 1; k < STAGES; k++) begin
        a_d[k]      = a_q[k-1];
        b_d[k]      = b_q[k-1];
        approx_d[k] = approx_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        // The stored carry is the raw carry out; the cut is applied here so
        // that the top stage still reports its real carry out in both modes.
        cin_k   = carry_q[k] & ~(approx_q[k] && (k != 0));
        seg_sum = {1'b0, a_q[k][k*SEG +: SEG]} + {1'b0, b_q[k][k*SEG +: SEG]}
                + {{SEG{1'b0}}, cin_k};
        sum_d[k+1]                = sum_q[k];
        sum_d[k+1][k*SEG +: SEG]  = seg_sum[SEG-1:0];
        carry_d[k+1]              = seg_sum[SEG];
        valid_d[k+1]              = valid_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        valid_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]      <= '0;
        b_q[k]      <= '0;
        approx_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k <= STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]      <= a_d[k];
        b_q[k]      <= b_d[k];
        approx_q[k] <= approx_d[k];
      end
    end
  end

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Testbench for seg_pipe_adder. An N=8/SEG=4 instance runs the directed
// vectors. An N=16/SEG=4 instance runs the random streams, backpressure and
// reset scenarios against an arithmetic reference model and an expected queue.
module tb_seg_pipe_adder;

  localparam int W   = 16;
  localparam int SW  = 4;
  localparam int LAT = W / SW;

  logic clk;
  logic rst_n;

  // 16-bit instance
  logic          in_valid, in_ready, cin, approx, out_valid, out_ready;
  logic [W-1:0]  a, b;
  logic [W:0]    result;

  // 8-bit instance
  logic          in_valid8, in_ready8, cin8, approx8, out_valid8, out_ready8;
  logic [7:0]    a8, b8;
  logic [8:0]    result8;

  int n_chk = 0;
  int n_err = 0;

  logic [W:0] exp_q[$];
  logic       prev_stall;
  logic [W:0] prev_res;
  logic       last_ov;

  seg_pipe_adder #(.N(W), .SEG(SW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .approx(approx),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  seg_pipe_adder #(.N(8), .SEG(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .approx(approx8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact mode is plain integer addition; carry-cut mode adds each
  // segment on its own (cin only into the lowest) and keeps the top carry.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic apx);
    longint unsigned mask, s, r;
    if (!apx) return W'(0) + {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    mask = (64'd1 << SW) - 1;
    r = 0;
    s = 0;
    for (int k = 0; k < LAT; k++) begin
      s = ((longint'(x) >> (k*SW)) & mask) + ((longint'(y) >> (k*SW)) & mask)
        + ((k == 0) ? longint'(c) : 0);
      r = r | ((s & mask) << (k*SW));
    end
    r = r | ((s >> SW) << W);
    return r[W:0];
  endfunction

  // ---------------- driver (16-bit) ----------------
  // Drives one cycle at the falling edge, then scores both handshakes that
  // will occur at the following rising edge.
  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic iapx, input logic ordy);
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; cin = ic; approx = iapx; out_ready = ordy;
    #1;
    last_ov = out_valid;
    check("in_ready", in_ready, !(out_valid && !ordy));
    if (prev_stall) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_result", result, prev_res);
    end
    if (out_valid && ordy) begin
      check("orphan", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check("result", result, exp_q.pop_front());
    end
    if (iv && in_ready) exp_q.push_back(ref_sum(ia, ib, ic, iapx));
    prev_stall = out_valid && !ordy;
    prev_res   = result;
  endtask

  task automatic rnd_cycle(input logic iv, input logic ordy);
    cycle(iv, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !last_ov) break;
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- driver (8-bit, directed) ----------------
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                      input logic iapx, input logic [8:0] exp, input string tag);
    int lat;
    lat = -1;
    @(negedge clk);
    in_valid8 = 1'b1; a8 = ia; b8 = ib; cin8 = ic; approx8 = iapx;
    @(negedge clk);
    in_valid8 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (out_valid8) begin
        lat = k - 1;
        check(tag, result8, exp);
        break;
      end
      @(negedge clk);
    end
    check({tag, "_lat"}, lat, 2);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [W:0] held;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; approx = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; approx8 = 1'b0; out_ready8 = 1'b1;
    prev_stall = 1'b0; prev_res = '0; last_ov = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid8", out_valid8, 1'b0);

    // Directed 8-bit vectors
    run8(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, "d8_exact_ff01");
    run8(8'hFF, 8'h01, 1'b0, 1'b1, 9'h0F0, "d8_apx_ff01");
    run8(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, "d8_exact_ffff");
    run8(8'hFF, 8'hFF, 1'b1, 1'b1, 9'h1EF, "d8_apx_ffff");

    // Back-to-back random stream
    for (int i = 0; i < 100; i++) rnd_cycle(1'b1, 1'b1);
    drain();

    // Boundary operands on the 16-bit instance
    cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    drain();

    // Backpressure: fill the pipe, stall 5 cycles with input still offered
    for (int i = 0; i < LAT + 2; i++) rnd_cycle(1'b1, 1'b1);
    held = result;
    for (int i = 0; i < 5; i++) begin
      rnd_cycle(1'b1, 1'b0);
      check("bp_in_ready", in_ready, 1'b0);
      if (i > 0) check("bp_stable", result, held);
      held = result;
    end
    drain();

    // Random in_valid / out_ready toggling
    for (int i = 0; i < 400; i++)
      rnd_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    drain();

    // Reset with two transactions in flight
    rnd_cycle(1'b1, 1'b1);
    rnd_cycle(1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_result", result, '0);
    exp_q.delete();
    prev_stall = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      check("no_ghost", out_valid, 1'b0);
    end

    // Latency after reset
    cycle(1'b1, 16'h1234, 16'h0FCD, 1'b1, 1'b0, 1'b1);
    lat = -1;
    for (int j = 1; j <= 20; j++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      if (last_ov) begin
        lat = j - 1;
        break;
      end
    end
    check("post_rst_latency", lat, LAT);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
